// File: rtl/digit_frame_arbiter_pkg.sv
// Shared constants, types and helpers for the digit frame arbiter and the screen renderer.
package digit_frame_arbiter_pkg;

    localparam int unsigned NUM_SLOTS = 12;
    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned BUS_W     = NUM_SLOTS * DIGIT_W;
    localparam int unsigned FRAME_SY  = 480;
    localparam logic [DIGIT_W-1:0] BLANK = 4'hF;

    typedef enum logic [0:0] {StIdle, StClear} arb_state_e;
    typedef enum logic [0:0] {ReqA, ReqB} req_id_e;

    // Slot 0 sits in the top nibble of the visible bus.
    function automatic int unsigned slot_to_bit_msb(int unsigned slot);
        return (BUS_W - 1) - DIGIT_W * slot;
    endfunction

    function automatic logic write_ok(logic [DIGIT_W-1:0] slot, logic [DIGIT_W-1:0] digit);
        return (slot < 4'(NUM_SLOTS)) && ((digit <= 4'd9) || (digit == BLANK));
    endfunction

endpackage

// File: rtl/digit_frame_arbiter_if.sv
// Two-requester digit write handshake between the game engine (A), keypad editor (B) and arbiter.
interface digit_frame_arbiter_if;
    import digit_frame_arbiter_pkg::*;

    logic               req_a;
    logic               req_b;
    logic [DIGIT_W-1:0] slot_a;
    logic [DIGIT_W-1:0] slot_b;
    logic [DIGIT_W-1:0] digit_a;
    logic [DIGIT_W-1:0] digit_b;
    logic               gnt_a;
    logic               gnt_b;

    modport master (
        output req_a, req_b, slot_a, slot_b, digit_a, digit_b,
        input  gnt_a, gnt_b
    );

    modport slave (
        input  req_a, req_b, slot_a, slot_b, digit_a, digit_b,
        output gnt_a, gnt_b
    );

endinterface

// File: rtl/frame_tick_detect.sv
// Single-cycle pulse on the rising edge of the commit-point match, independent of clock ratio.
module frame_tick_detect
    import digit_frame_arbiter_pkg::*;
#(
    parameter int unsigned FrameSy = FRAME_SY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] sx_i,
    input  logic [9:0] sy_i,
    output logic       tick_o
);

    logic match;
    logic match_q;

    assign match = (sx_i == 10'd0) && (sy_i == 10'(FrameSy));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match;
        end
    end

    assign tick_o = match && !match_q;

endmodule

// File: rtl/digit_frame_arbiter.sv
// Round-robin digit writes into a shadow buffer, published once per frame at vertical blanking.
module digit_frame_arbiter
    import digit_frame_arbiter_pkg::*;
#(
    parameter int unsigned FrameSy = FRAME_SY
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           sx_i,
    input  logic [9:0]           sy_i,
    input  logic                 clr_i,
    digit_frame_arbiter_if.slave req_if,
    output logic [BUS_W-1:0]     numbers_concat_o,
    output logic                 commit_o,
    output logic                 err_o,
    output logic                 busy_o
);

    arb_state_e         state_q, state_d;
    req_id_e            last_q, last_d;
    logic [DIGIT_W-1:0] shadow_q [NUM_SLOTS];
    logic [DIGIT_W-1:0] shadow_d [NUM_SLOTS];
    logic [DIGIT_W-1:0] idx_q, idx_d;
    logic               dirty_q, dirty_d;
    logic               pend_q, pend_d;
    logic               commit_q, commit_d;
    logic               err_q, err_d;
    logic [BUS_W-1:0]   vis_q, vis_d;
    logic [BUS_W-1:0]   shadow_flat;
    logic               tick;
    logic               gnt_a, gnt_b;
    logic [DIGIT_W-1:0] w_slot, w_digit;

    frame_tick_detect #(
        .FrameSy(FrameSy)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .sx_i  (sx_i),
        .sy_i  (sy_i),
        .tick_o(tick)
    );

    // clr pre-empts any grant on the same cycle.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (state_q == StIdle && !clr_i && !rst) begin
            if (req_if.req_a && req_if.req_b) begin
                gnt_a = (last_q == ReqB);
                gnt_b = (last_q == ReqA);
            end else begin
                gnt_a = req_if.req_a;
                gnt_b = req_if.req_b;
            end
        end
    end

    assign w_slot  = gnt_a ? req_if.slot_a  : req_if.slot_b;
    assign w_digit = gnt_a ? req_if.digit_a : req_if.digit_b;

    always_comb begin
        shadow_flat = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            shadow_flat[slot_to_bit_msb(i) -: DIGIT_W] = shadow_q[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        dirty_d  = dirty_q;
        pend_d   = pend_q;
        vis_d    = vis_q;
        commit_d = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Commit samples the pre-write shadow; a coincident write keeps dirty set.
                if (tick || pend_q) begin
                    pend_d = 1'b0;
                    if (dirty_q) begin
                        vis_d    = shadow_flat;
                        dirty_d  = 1'b0;
                        commit_d = 1'b1;
                    end
                end
                if (gnt_a || gnt_b) begin
                    last_d = gnt_a ? ReqA : ReqB;
                    if (write_ok(w_slot, w_digit)) begin
                        shadow_d[w_slot] = w_digit;
                        dirty_d          = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (clr_i) begin
                    state_d = StClear;
                    idx_d   = '0;
                end
            end
            StClear: begin
                if (tick) begin
                    pend_d = 1'b1;
                end
                shadow_d[idx_q] = BLANK;
                dirty_d         = 1'b1;
                if (idx_q == 4'(NUM_SLOTS - 1)) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            last_q   <= ReqB;
            shadow_q <= '{default: BLANK};
            idx_q    <= '0;
            dirty_q  <= 1'b0;
            pend_q   <= 1'b0;
            vis_q    <= '1;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            dirty_q  <= dirty_d;
            pend_q   <= pend_d;
            vis_q    <= vis_d;
            commit_q <= commit_d;
            err_q    <= err_d;
        end
    end

    assign req_if.gnt_a     = gnt_a;
    assign req_if.gnt_b     = gnt_b;
    assign numbers_concat_o = vis_q;
    assign commit_o         = commit_q;
    assign err_o            = err_q;
    assign busy_o           = (state_q == StClear);

endmodule

// File: tb/tb_digit_frame_arbiter.sv
// Directed bench for digit_frame_arbiter: per-cycle compare against a behavioural model plus literals.
module tb_digit_frame_arbiter;
    import digit_frame_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  sx  = 10'd1;
    logic [9:0]  sy  = 10'd0;
    logic        clr = 1'b0;
    logic [47:0] numbers;
    logic        commit, err, busy;

    digit_frame_arbiter_if req_if ();

    digit_frame_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .sx_i            (sx),
        .sy_i            (sy),
        .clr_i           (clr),
        .req_if          (req_if),
        .numbers_concat_o(numbers),
        .commit_o        (commit),
        .err_o           (err),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int commits = 0;
    int errs = 0;
    int busy_cycles = 0;

    // Behavioural model: slot contents, visible word, and how many clear cycles remain.
    logic [3:0]  m_sh [12];
    logic [47:0] m_vis;
    bit          m_dirty, m_pend, m_prev_match, m_last_a, m_commit, m_err;
    int          m_clear_left;
    bit          eg_a, eg_b;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] pack_model();
        logic [47:0] v = '0;
        for (int i = 0; i < 12; i++) v = {v[43:0], m_sh[i]};
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 12; i++) m_sh[i] = 4'hF;
        m_vis = 48'hFFFF_FFFF_FFFF;
        m_dirty = 0; m_pend = 0; m_prev_match = 0; m_last_a = 0;
        m_commit = 0; m_err = 0; m_clear_left = 0;
    endfunction

    function automatic void exp_gnt(output bit ga, output bit gb);
        ga = 0;
        gb = 0;
        if (!rst && m_clear_left == 0 && !clr) begin
            if (req_if.req_a && req_if.req_b) begin
                ga = !m_last_a;
                gb = m_last_a;
            end else begin
                ga = req_if.req_a;
                gb = req_if.req_b;
            end
        end
    endfunction

    function automatic void model_step();
        bit ga, gb, match, tk;
        logic [3:0] s, d;
        exp_gnt(ga, gb);
        match = (sx == 10'd0) && (sy == 10'd480);
        tk = match && !m_prev_match;
        m_prev_match = match;
        m_commit = 0;
        m_err = 0;
        if (m_clear_left > 0) begin
            if (tk) m_pend = 1;
            m_sh[12 - m_clear_left] = 4'hF;
            m_dirty = 1;
            m_clear_left--;
        end else begin
            if ((tk || m_pend) && m_dirty) begin
                m_vis = pack_model();
                m_dirty = 0;
                m_commit = 1;
            end
            m_pend = 0;
            if (ga || gb) begin
                s = ga ? req_if.slot_a : req_if.slot_b;
                d = ga ? req_if.digit_a : req_if.digit_b;
                m_last_a = ga;
                if (s < 4'd12 && (d < 4'd10 || d == 4'hF)) begin
                    m_sh[s] = d;
                    m_dirty = 1;
                end else begin
                    m_err = 1;
                end
            end
            if (clr) m_clear_left = 12;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        exp_gnt(eg_a, eg_b);
        check("gnt_a", 48'(req_if.gnt_a), 48'(eg_a));
        check("gnt_b", 48'(req_if.gnt_b), 48'(eg_b));
        check("numbers", numbers, m_vis);
        check("commit", 48'(commit), 48'(m_commit));
        check("err", 48'(err), 48'(m_err));
        check("busy", 48'(busy), 48'(m_clear_left > 0));
        if (commit === 1'b1) commits++;
        if (err === 1'b1) errs++;
        if (busy === 1'b1) busy_cycles++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_tick();
        sx = 10'd0;
        sy = 10'd480;
        cyc(2);
        sx = 10'd1;
        sy = 10'd0;
        cyc(2);
    endtask

    task automatic do_write(input bit a, input logic [3:0] slot, input logic [3:0] digit);
        int n = 0;
        if (a) begin
            req_if.req_a = 1; req_if.slot_a = slot; req_if.digit_a = digit;
        end else begin
            req_if.req_b = 1; req_if.slot_b = slot; req_if.digit_b = digit;
        end
        @(negedge clk);
        while (!(a ? req_if.gnt_a : req_if.gnt_b) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("write_granted", 48'(n < 40), 48'd1);
        @(posedge clk);
        #1;
        req_if.req_a = 0;
        req_if.req_b = 0;
    endtask

    int c0, e0;
    logic [2:0] ga_seq, gb_seq;

    initial begin
        req_if.req_a = 0; req_if.req_b = 0;
        req_if.slot_a = 0; req_if.slot_b = 0;
        req_if.digit_a = 0; req_if.digit_b = 0;
        cyc(2);
        rst = 0;
        cyc(1);
        check("reset_numbers", numbers, 48'hFFFF_FFFF_FFFF);
        check("reset_busy", 48'(busy), 48'd0);

        // Single write becomes visible at the next tick.
        c0 = commits;
        do_write(1, 4'd0, 4'd3);
        cyc(3);
        check("pre_tick_hidden", numbers, 48'hFFFF_FFFF_FFFF);
        frame_tick();
        check("first_commit", numbers, 48'h3FFF_FFFF_FFFF);
        check("first_commit_pulses", 48'(commits - c0), 48'd1);

        // Make B the last winner, then hold both requesters.
        do_write(0, 4'd5, 4'd1);
        req_if.req_a = 1; req_if.slot_a = 4'd1; req_if.digit_a = 4'd5;
        req_if.req_b = 1; req_if.slot_b = 4'd1; req_if.digit_b = 4'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ga_seq[2-i] = req_if.gnt_a;
            gb_seq[2-i] = req_if.gnt_b;
        end
        @(posedge clk);
        #1;
        req_if.req_a = 0;
        req_if.req_b = 0;
        check("rr_seq_a", 48'(ga_seq), 48'b101);
        check("rr_seq_b", 48'(gb_seq), 48'b010);
        frame_tick();
        check("rr_commit", numbers, 48'h35FF_F1FF_FFFF);

        // Rejected writes: granted, err pulses, nothing commits.
        e0 = errs;
        c0 = commits;
        do_write(1, 4'd12, 4'd2);
        do_write(0, 4'd4, 4'd11);
        cyc(2);
        check("err_pulses", 48'(errs - e0), 48'd2);
        frame_tick();
        check("err_no_commit", 48'(commits - c0), 48'd0);
        check("err_numbers", numbers, 48'h35FF_F1FF_FFFF);

        // Clear with the tick landing mid-sequence.
        c0 = commits;
        busy_cycles = 0;
        clr = 1;
        cyc(1);
        clr = 0;
        cyc(4);
        sx = 10'd0;
        sy = 10'd480;
        cyc(2);
        sx = 10'd1;
        sy = 10'd0;
        cyc(15);
        check("clear_busy_len", 48'(busy_cycles), 48'd12);
        check("clear_numbers", numbers, 48'hFFFF_FFFF_FFFF);
        check("clear_commit", 48'(commits - c0), 48'd1);

        // Write coincident with the tick lands in the following frame.
        do_write(1, 4'd0, 4'd8);
        req_if.req_a = 1; req_if.slot_a = 4'd2; req_if.digit_a = 4'd9;
        sx = 10'd0;
        sy = 10'd480;
        cyc(1);
        req_if.req_a = 0;
        cyc(1);
        sx = 10'd1;
        sy = 10'd0;
        cyc(2);
        check("tick_write_old", numbers, 48'h8FFF_FFFF_FFFF);
        frame_tick();
        check("tick_write_new", numbers, 48'h8F9F_FFFF_FFFF);

        // Reset in the sixth clear cycle aborts the sequence.
        clr = 1;
        cyc(1);
        clr = 0;
        cyc(5);
        rst = 1;
        #1;
        check("rst_busy", 48'(busy), 48'd0);
        check("rst_numbers", numbers, 48'hFFFF_FFFF_FFFF);
        check("rst_commit", 48'(commit), 48'd0);
        check("rst_err", 48'(err), 48'd0);
        cyc(1);
        rst = 0;
        cyc(1);
        req_if.req_a = 1; req_if.slot_a = 4'd3; req_if.digit_a = 4'd4;
        req_if.req_b = 1; req_if.slot_b = 4'd3; req_if.digit_b = 4'd6;
        @(negedge clk);
        check("rst_tie_a", 48'(req_if.gnt_a), 48'd1);
        check("rst_tie_b", 48'(req_if.gnt_b), 48'd0);
        @(posedge clk);
        #1;
        req_if.req_a = 0;
        req_if.req_b = 0;
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
